// File: rtl/vga_frame_checker_pkg.sv
// Shared types and constants for the VGA frame checker.
package vga_frame_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } frame_state_t;

  localparam int unsigned PIXEL_W        = 24;
  localparam logic [10:0] MIN_X_SENTINEL = 11'h7FF;
  localparam logic [9:0]  MIN_Y_SENTINEL = 10'h3FF;
  localparam logic [19:0] COUNT_MAX      = 20'hFFFFF;

endpackage

// File: rtl/vga_frame_checker_bbox_accumulator.sv
// Bounding box and saturating hit count over a stream of (x, y) hits.
// Outputs are the updated values including the current cycle's hit, so the
// owner can snapshot a result that contains a hit landing on the same cycle.
module vga_frame_checker_bbox_accumulator
  import vga_frame_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  output logic [19:0] count,
  output logic [10:0] min_x,
  output logic [10:0] max_x,
  output logic [9:0]  min_y,
  output logic [9:0]  max_y
);

  logic [19:0] count_q;
  logic [10:0] min_x_q;
  logic [10:0] max_x_q;
  logic [9:0]  min_y_q;
  logic [9:0]  max_y_q;

  // Fold the current hit into the stored box and count.
  always_comb begin
    count = count_q;
    min_x = min_x_q;
    max_x = max_x_q;
    min_y = min_y_q;
    max_y = max_y_q;
    if (enable) begin
      if (count_q != COUNT_MAX) count = count_q + 20'd1;
      if (x < min_x_q) min_x = x;
      if (x > max_x_q) max_x = x;
      if (y < min_y_q) min_y = y;
      if (y > max_y_q) max_y = y;
    end
  end

  // Hold the accumulated state; clear restores the empty-box sentinels.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
      min_x_q <= MIN_X_SENTINEL;
      max_x_q <= '0;
      min_y_q <= MIN_Y_SENTINEL;
      max_y_q <= '0;
    end else begin
      count_q <= count;
      min_x_q <= min_x;
      max_x_q <= max_x;
      min_y_q <= min_y;
      max_y_q <= max_y;
    end
  end

endmodule

// File: rtl/vga_frame_checker.sv
// Pixel-interface receiver: rebuilds active-area coordinates, measures frame
// geometry and locates key-colour pixels, publishing one result set per frame.
module vga_frame_checker
  import vga_frame_checker_pkg::*;
#(
  parameter int unsigned          EXPECT_WIDTH  = 1024,
  parameter int unsigned          EXPECT_HEIGHT = 768,
  parameter logic [PIXEL_W-1:0]   KEY_MASK      = 24'hFF_FF_FF
) (
  input  logic               vclock,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic [PIXEL_W-1:0] key_color,
  output logic               frame_done,
  output logic               locked,
  output logic               geometry_ok,
  output logic               sync_error,
  output logic [10:0]        active_width,
  output logic [9:0]         active_height,
  output logic [19:0]        match_count,
  output logic               match_found,
  output logic [10:0]        min_x,
  output logic [10:0]        max_x,
  output logic [9:0]         min_y,
  output logic [9:0]         max_y
);

  localparam logic [10:0] EXP_W = 11'(EXPECT_WIDTH);
  localparam logic [9:0]  EXP_H = 10'(EXPECT_HEIGHT);

  logic               hsync_s1, vsync_s1, blank_s1;
  logic [PIXEL_W-1:0] pixel_s1, key_s1;
  logic               vsync_s2, blank_s2;

  frame_state_t       state;
  logic [PIXEL_W-1:0] key_lat;

  logic [10:0] col, col_n, width, width_n;
  logic [9:0]  row, row_n;
  logic        first_line, first_line_n;
  logic        width_err, width_err_n;
  logic        sat_err, sat_err_n;
  logic        sync_err, sync_err_n;
  logic        geom_n;

  logic        boundary, blank_rise, is_match, acc_enable, acc_clear;
  logic [19:0] acc_count;
  logic [10:0] acc_min_x, acc_max_x;
  logic [9:0]  acc_min_y, acc_max_y;

  // Input register stage (S1) and its one-cycle history (S2) for edge detection.
  always_ff @(posedge vclock) begin
    if (reset) begin
      hsync_s1 <= 1'b1;
      vsync_s1 <= 1'b1;
      blank_s1 <= 1'b1;
      pixel_s1 <= '0;
      key_s1   <= '0;
      vsync_s2 <= 1'b1;
      blank_s2 <= 1'b1;
    end else begin
      hsync_s1 <= hsync;
      vsync_s1 <= vsync;
      blank_s1 <= blank;
      pixel_s1 <= pixel;
      key_s1   <= key_color;
      vsync_s2 <= vsync_s1;
      blank_s2 <= blank_s1;
    end
  end

  assign boundary   = vsync_s2 & ~vsync_s1;
  assign blank_rise = blank_s1 & ~blank_s2;
  assign is_match   = ((pixel_s1 & KEY_MASK) == (key_lat & KEY_MASK));
  assign acc_enable = (state == MEASURE) && !blank_s1 && is_match;
  assign acc_clear  = (state == ARM);

  // Next coordinate / error state; reporting uses these so the boundary
  // cycle's own pixel and sync check still belong to the frame being closed.
  always_comb begin
    col_n        = col;
    row_n        = row;
    width_n      = width;
    first_line_n = first_line;
    width_err_n  = width_err;
    sat_err_n    = sat_err;
    sync_err_n   = sync_err;
    if (state == MEASURE) begin
      if (!blank_s1) begin
        if (col == MIN_X_SENTINEL) sat_err_n = 1'b1;
        else                       col_n = col + 11'd1;
        if (!hsync_s1 || !vsync_s1) sync_err_n = 1'b1;
      end
      if (blank_rise && (col != '0)) begin
        col_n = '0;
        if (row == MIN_Y_SENTINEL) sat_err_n = 1'b1;
        else                       row_n = row + 10'd1;
        if (!first_line) begin
          width_n      = col;
          first_line_n = 1'b1;
        end else if (col != width) begin
          width_err_n = 1'b1;
        end
      end
    end
    geom_n = (width_n == EXP_W) && (row_n == EXP_H) &&
             !width_err_n && !sync_err_n && !sat_err_n;
  end

  // Frame state machine with registered result outputs.
  always_ff @(posedge vclock) begin
    if (reset) begin
      state         <= IDLE;
      key_lat       <= '0;
      col           <= '0;
      row           <= '0;
      width         <= '0;
      first_line    <= 1'b0;
      width_err     <= 1'b0;
      sat_err       <= 1'b0;
      sync_err      <= 1'b0;
      frame_done    <= 1'b0;
      locked        <= 1'b0;
      geometry_ok   <= 1'b0;
      sync_error    <= 1'b0;
      active_width  <= '0;
      active_height <= '0;
      match_count   <= '0;
      match_found   <= 1'b0;
      min_x         <= MIN_X_SENTINEL;
      max_x         <= '0;
      min_y         <= MIN_Y_SENTINEL;
      max_y         <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (boundary) state <= ARM;
        end
        ARM: begin
          col        <= '0;
          row        <= '0;
          width      <= '0;
          first_line <= 1'b0;
          width_err  <= 1'b0;
          sat_err    <= 1'b0;
          sync_err   <= 1'b0;
          key_lat    <= key_s1;
          state      <= MEASURE;
        end
        MEASURE: begin
          col        <= col_n;
          row        <= row_n;
          width      <= width_n;
          first_line <= first_line_n;
          width_err  <= width_err_n;
          sat_err    <= sat_err_n;
          sync_err   <= sync_err_n;
          if (boundary) begin
            state         <= ARM;
            frame_done    <= 1'b1;
            locked        <= 1'b1;
            geometry_ok   <= geom_n;
            sync_error    <= sync_err_n;
            active_width  <= width_n;
            active_height <= row_n;
            match_count   <= acc_count;
            match_found   <= (acc_count != '0);
            min_x         <= acc_min_x;
            max_x         <= acc_max_x;
            min_y         <= acc_min_y;
            max_y         <= acc_max_y;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vga_frame_checker_bbox_accumulator u_bbox (
    .clk    (vclock),
    .reset  (reset),
    .clear  (acc_clear),
    .enable (acc_enable),
    .x      (col),
    .y      (row),
    .count  (acc_count),
    .min_x  (acc_min_x),
    .max_x  (acc_max_x),
    .min_y  (acc_min_y),
    .max_y  (acc_max_y)
  );

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker on a synthetic 8x4 active frame.
module tb_vga_frame_checker;

  logic        vclock = 1'b0;
  logic        reset  = 1'b1;
  logic        hsync  = 1'b1;
  logic        vsync  = 1'b1;
  logic        blank  = 1'b1;
  logic [23:0] pixel  = '0;
  logic [23:0] key1   = 24'hFF_00_00;
  logic [23:0] key2   = 24'hFF_12_34;

  logic        frame_done, locked, geometry_ok, sync_error, match_found;
  logic [10:0] active_width, min_x, max_x;
  logic [9:0]  active_height, min_y, max_y;
  logic [19:0] match_count;

  logic        frame_done2, locked2, geometry_ok2, sync_error2, match_found2;
  logic [10:0] active_width2, min_x2, max_x2;
  logic [9:0]  active_height2, min_y2, max_y2;
  logic [19:0] match_count2;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  int fd_base  = 0;

  always #5 vclock = ~vclock;

  vga_frame_checker #(.EXPECT_WIDTH(8), .EXPECT_HEIGHT(4), .KEY_MASK(24'hFF_FF_FF)) u1 (
    .vclock(vclock), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .pixel(pixel), .key_color(key1), .frame_done(frame_done), .locked(locked),
    .geometry_ok(geometry_ok), .sync_error(sync_error), .active_width(active_width),
    .active_height(active_height), .match_count(match_count), .match_found(match_found),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y)
  );

  vga_frame_checker #(.EXPECT_WIDTH(8), .EXPECT_HEIGHT(4), .KEY_MASK(24'hFF_00_00)) u2 (
    .vclock(vclock), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .pixel(pixel), .key_color(key2), .frame_done(frame_done2), .locked(locked2),
    .geometry_ok(geometry_ok2), .sync_error(sync_error2), .active_width(active_width2),
    .active_height(active_height2), .match_count(match_count2), .match_found(match_found2),
    .min_x(min_x2), .max_x(max_x2), .min_y(min_y2), .max_y(max_y2)
  );

  always @(negedge vclock) if (frame_done === 1'b1) fd_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic h, input logic v, input logic b, input logic [23:0] p);
    hsync = h; vsync = v; blank = b; pixel = p;
    @(posedge vclock);
    #1;
  endtask

  function automatic logic [23:0] pix(input bit red, input int x, input int y);
    if (red && ((x == 2 && y == 1) || (x == 3 && y == 1) || (x == 2 && y == 2)))
      return 24'hFF_00_00;
    if (red && x == 5 && y == 3)
      return 24'hFF_00_01;
    return 24'h00_00_00;
  endfunction

  task automatic line_tail();
    cyc(1, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(1, 1, 1, 0);
  endtask

  task automatic send_line(input int y, input int w, input bit red);
    for (int x = 0; x < w; x++) cyc(1, 1, 0, pix(red, x, y));
    line_tail();
  endtask

  task automatic send_vblank();
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0);
  endtask

  task automatic send_frame(input bit red, input int short_line);
    send_vblank();
    for (int y = 0; y < 4; y++) send_line(y, (y == short_line) ? 7 : 8, red);
  endtask

  initial begin
    // reset state
    repeat (3) cyc(1, 1, 1, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_min_x", min_x, 32'h7FF);
    chk("rst_min_y", min_y, 32'h3FF);
    chk("rst_max_x", max_x, 0);
    chk("rst_count", match_count, 0);
    reset = 1'b0;

    // first boundary arms only
    send_frame(0, -1);
    chk("f1_no_done", fd_count, 0);
    chk("f1_locked", locked, 0);

    // second boundary reports the clean frame
    send_frame(0, -1);
    chk("f2_done", fd_count, 1);
    chk("f2_locked", locked, 1);
    chk("f2_width", active_width, 8);
    chk("f2_height", active_height, 4);
    chk("f2_geom", geometry_ok, 1);
    chk("f2_found", match_found, 0);
    chk("f2_sync", sync_error, 0);

    // red pixels; u2 masks to red channel only so the FF0001 pixel also hits
    send_frame(1, -1);
    send_frame(0, -1);
    chk("red_count", match_count, 3);
    chk("red_found", match_found, 1);
    chk("red_min_x", min_x, 2);
    chk("red_max_x", max_x, 3);
    chk("red_min_y", min_y, 1);
    chk("red_max_y", max_y, 2);
    chk("red_geom", geometry_ok, 1);
    chk("mask_count", match_count2, 4);
    chk("mask_min_x", min_x2, 2);
    chk("mask_max_x", max_x2, 5);
    chk("mask_min_y", min_y2, 1);
    chk("mask_max_y", max_y2, 3);

    // short line 3; the report seen now is the empty frame before it
    send_frame(0, 3);
    chk("empty_found", match_found, 0);
    chk("empty_min_x", min_x, 32'h7FF);
    chk("empty_max_y", max_y, 0);
    send_frame(0, -1);
    chk("short_geom", geometry_ok, 0);
    chk("short_width", active_width, 8);
    chk("short_height", active_height, 4);
    chk("short_sync", sync_error, 0);
    chk("short_done_cnt", fd_count, 5);

    // vsync falls during active video on line 2
    send_vblank();
    send_line(0, 8, 0);
    send_line(1, 8, 0);
    for (int x = 0; x < 3; x++) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("vs_done_lat1", frame_done, 0);
    cyc(1, 0, 1, 0);
    chk("vs_done_lat2", frame_done, 1);
    chk("vs_sync", sync_error, 1);
    chk("vs_height", active_height, 2);
    chk("vs_width", active_width, 8);
    chk("vs_geom", geometry_ok, 0);
    cyc(1, 0, 1, 0);
    chk("vs_done_pulse", frame_done, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0);
    send_frame(0, -1);
    send_frame(0, -1);
    chk("recover_geom", geometry_ok, 1);
    chk("recover_sync", sync_error, 0);

    // one-cycle reset in the middle of line 1
    send_vblank();
    send_line(0, 8, 0);
    for (int x = 0; x < 4; x++) cyc(1, 1, 0, 0);
    fd_base = fd_count;
    reset = 1'b1;
    cyc(1, 1, 0, 0);
    reset = 1'b0;
    chk("mr_locked", locked, 0);
    chk("mr_min_x", min_x, 32'h7FF);
    chk("mr_width", active_width, 0);
    chk("mr_geom", geometry_ok, 0);
    for (int x = 0; x < 3; x++) cyc(1, 1, 0, 0);
    line_tail();
    send_line(2, 8, 0);
    send_line(3, 8, 0);
    send_frame(0, -1);
    chk("mr_no_done", fd_count, fd_base);
    chk("mr_still_unlocked", locked, 0);
    send_frame(0, -1);
    chk("mr_resume_done", fd_count, fd_base + 1);
    chk("mr_resume_locked", locked, 1);
    chk("mr_resume_geom", geometry_ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
